approx_serial_comparator: RTL and testbench

//  Parametrised, digit-serial, approximate magnitude comparator; successor to the fixed 4-bit combinational comparator.

---
 rtl/approx_cmp_pkg.sv | 19 +
 rtl/cmp_chunk_slice.sv | 15 +
 rtl/approx_serial_comparator.sv | 131 +++++++++++++
 tb/tb_approx_serial_comparator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/approx_cmp_pkg.sv
// Shared types and helpers for the digit-serial approximate comparator.
// Imported by approx_serial_comparator.
package approx_cmp_pkg;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} cmp_state_t;

  typedef enum logic [1:0] {RES_NONE, RES_EQ, RES_GT, RES_LT} cmp_res_t;

  // Bits needed to index n items; never returns 0, so a one-chunk build still gets a 1-bit counter.
  function automatic int clog2_safe(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/cmp_chunk_slice.sv
// Combinational magnitude compare of one CHUNK-bit digit.
// A single instance is time-shared across all digits by the top-level mux.
module cmp_chunk_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_c,
  input  logic [CHUNK-1:0] b_c,
  output logic             c_gt,
  output logic             c_lt
);

  assign c_gt = (a_c > b_c);
  assign c_lt = (a_c < b_c);

endmodule

// File: rtl/approx_serial_comparator.sv
// Digit-serial, MSB-first approximate magnitude comparator on valid/ready streams.
// Build option: define APPROX_CMP_EARLY_TERM_EN to stop scanning at the first differing digit.
module approx_serial_comparator
  import approx_cmp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 4,
  parameter int APPROX_LSB = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int SIG_W  = WIDTH - APPROX_LSB;
  localparam int NCHUNK = SIG_W / CHUNK;
  localparam int IDX_W  = clog2_safe(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

`ifdef APPROX_CMP_EARLY_TERM_EN
  localparam bit EARLY_TERM = 1'b1;
`else
  localparam bit EARLY_TERM = 1'b0;
`endif

  if ((SIG_W < CHUNK) || ((SIG_W % CHUNK) != 0)) begin : g_bad_cfg
    $error("approx_serial_comparator: WIDTH-APPROX_LSB must be a non-zero multiple of CHUNK");
  end

  // The ignored low bits are dropped at capture time, never stored.
  if (APPROX_LSB > 0) begin : g_lsb_drop
    logic unused_lsb;
    assign unused_lsb = ^{a[APPROX_LSB-1:0], b[APPROX_LSB-1:0]};
  end

  cmp_state_t                         state;
  logic [NCHUNK-1:0][CHUNK-1:0]       a_q;
  logic [NCHUNK-1:0][CHUNK-1:0]       b_q;
  logic [IDX_W-1:0]                   idx;
  cmp_res_t                           res_q;
  cmp_res_t                           res_next;
  cmp_res_t                           res_final;
  logic [CHUNK-1:0]                   a_c;
  logic [CHUNK-1:0]                   b_c;
  logic                               c_gt;
  logic                               c_lt;
  logic                               scan_exit;

  // Digit idx counts from the MSB end, so the packed index runs downward.
  assign a_c = a_q[LAST_IDX - idx];
  assign b_c = b_q[LAST_IDX - idx];

  cmp_chunk_slice #(.CHUNK(CHUNK)) u_slice (
    .a_c  (a_c),
    .b_c  (b_c),
    .c_gt (c_gt),
    .c_lt (c_lt)
  );

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    res_next = res_q;
    if (res_q == RES_NONE) begin
      if (c_gt)      res_next = RES_GT;
      else if (c_lt) res_next = RES_LT;
    end
    res_final = (res_next == RES_NONE) ? RES_EQ : res_next;
    scan_exit = (idx == LAST_IDX) || (EARLY_TERM && (res_next != RES_NONE));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      idx       <= '0;
      res_q     <= RES_NONE;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a[WIDTH-1:APPROX_LSB];
            b_q      <= b[WIDTH-1:APPROX_LSB];
            idx      <= '0;
            res_q    <= RES_NONE;
            in_ready <= 1'b0;
            state    <= SCAN;
          end
        end
        SCAN: begin
          res_q <= res_next;
          if (scan_exit) begin
            out_valid <= 1'b1;
            eq        <= (res_final == RES_EQ);
            gt        <= (res_final == RES_GT);
            lt        <= (res_final == RES_LT);
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            eq        <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_serial_comparator.sv
// Self-checking bench: default build (APPROX_LSB=4) and an exact build (APPROX_LSB=0).
// Honors APPROX_CMP_EARLY_TERM_EN for the expected latencies.
module tb_approx_serial_comparator;

`ifdef APPROX_CMP_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [2:0] R_EQ = 3'b100;
  localparam logic [2:0] R_GT = 3'b010;
  localparam logic [2:0] R_LT = 3'b001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_v [2];
  logic        in_ready_v [2];
  logic [15:0] a_v [2];
  logic [15:0] b_v [2];
  logic        out_valid_v[2];
  logic        out_ready_v[2];
  logic        eq_v[2];
  logic        gt_v[2];
  logic        lt_v[2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  approx_serial_comparator #(.WIDTH(16), .CHUNK(4), .APPROX_LSB(4)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .a(a_v[0]), .b(b_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]),
    .eq(eq_v[0]), .gt(gt_v[0]), .lt(lt_v[0])
  );

  approx_serial_comparator #(.WIDTH(16), .CHUNK(4), .APPROX_LSB(0)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .a(a_v[1]), .b(b_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]),
    .eq(eq_v[1]), .gt(gt_v[1]), .lt(lt_v[1])
  );

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  res;
    int          lat_et;
    int          lat_full;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: compare the kept upper bits as plain integers.
  function automatic logic [2:0] ref_res(input logic [15:0] a, input logic [15:0] b, input int lsb);
    logic [15:0] x;
    logic [15:0] y;
    x = a >> lsb;
    y = b >> lsb;
    if (x == y) return R_EQ;
    return (x > y) ? R_GT : R_LT;
  endfunction

  // Reference latency: position of the first differing hex digit, MSB first.
  function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b, input int lsb);
    int n;
    int sh;
    n = (16 - lsb) / 4;
    if (!EARLY) return n;
    for (int k = 0; k < n; k++) begin
      sh = 12 - 4 * k;
      if (((a >> sh) & 16'hF) != ((b >> sh) & 16'hF)) return k + 1;
    end
    return n;
  endfunction

  function automatic logic [4:0] status(input int d);
    return {in_ready_v[d], out_valid_v[d], eq_v[d], gt_v[d], lt_v[d]};
  endfunction

  // One transaction: accept, count edges to out_valid, optionally stall, then release.
  task automatic do_txn(input int d, input logic [15:0] av, input logic [15:0] bv, input int hold,
                        output logic [2:0] res, output int lat);
    @(negedge clk);
    check("idle in_ready", in_ready_v[d], 1);
    a_v[d] = av;
    b_v[d] = bv;
    in_valid_v[d]  = 1'b1;
    out_ready_v[d] = 1'b0;
    @(posedge clk); #1;
    in_valid_v[d] = 1'b0;
    a_v[d] = 16'($urandom);
    b_v[d] = 16'($urandom);
    check("scan in_ready", in_ready_v[d], 0);
    lat = 0;
    while (lat < 20 && !out_valid_v[d]) begin
      @(posedge clk); #1;
      lat++;
    end
    check("out_valid seen", out_valid_v[d], 1);
    res = {eq_v[d], gt_v[d], lt_v[d]};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid_v[d] = 1'b1;
      a_v[d] = 16'($urandom);
      b_v[d] = 16'($urandom);
      @(posedge clk); #1;
      check("hold stable", status(d), {2'b01, res});
    end
    @(negedge clk);
    in_valid_v[d]  = 1'b0;
    out_ready_v[d] = 1'b1;
    @(posedge clk); #1;
    check("release", status(d), 5'b10000);
    @(negedge clk);
    out_ready_v[d] = 1'b0;
  endtask

  vec_t        vecs[8];
  logic [2:0]  got;
  int          lat;
  logic [15:0] ra;
  logic [15:0] rb;
  int          d;

  initial begin
    vecs[0] = '{"equal",        16'h1234, 16'h1234, R_EQ, 3, 3};
    vecs[1] = '{"msb differs",  16'h8000, 16'h7FFF, R_GT, 1, 3};
    vecs[2] = '{"approx lsb",   16'h123F, 16'h1230, R_EQ, 3, 3};
    vecs[3] = '{"late diff",    16'h1200, 16'h1250, R_LT, 3, 3};
    vecs[4] = '{"first wins",   16'h3200, 16'h1F00, R_GT, 1, 3};
    vecs[5] = '{"zero vs max",  16'h0000, 16'hFFFF, R_LT, 1, 3};
    vecs[6] = '{"mid diff",     16'h1F00, 16'h1E00, R_GT, 2, 3};
    vecs[7] = '{"max approx",   16'hFFFF, 16'hFFF0, R_EQ, 3, 3};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid_v[i] = 1'b0; out_ready_v[i] = 1'b0; a_v[i] = '0; b_v[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    check("reset state dut0", status(0), 5'b10000);
    check("reset state dut1", status(1), 5'b10000);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_txn(0, vecs[i].a, vecs[i].b, 0, got, lat);
      check({"result ", vecs[i].name}, got, vecs[i].res);
      check({"latency ", vecs[i].name}, lat, EARLY ? vecs[i].lat_et : vecs[i].lat_full);
    end

    // Exact build: the low nibble now decides.
    do_txn(1, 16'h123F, 16'h1230, 0, got, lat);
    check("exact result", got, R_GT);
    check("exact latency", lat, 4);
    do_txn(1, 16'h1234, 16'h1234, 0, got, lat);
    check("exact equal", got, R_EQ);
    check("exact equal latency", lat, 4);

    // Backpressure with ignored in_valid pulses, then a fresh transaction.
    do_txn(0, 16'h3200, 16'h1F00, 5, got, lat);
    check("backpressure result", got, R_GT);
    do_txn(0, 16'h0100, 16'h0200, 0, got, lat);
    check("after backpressure", got, R_LT);

    for (int i = 0; i < 40; i++) begin
      d  = i % 2;
      ra = 16'($urandom);
      case ($urandom_range(2))
        0:       rb = 16'($urandom);
        1:       rb = ra;
        default: rb = ra ^ (16'h1 << $urandom_range(15));
      endcase
      do_txn(d, ra, rb, $urandom_range(2), got, lat);
      check("random result", got, ref_res(ra, rb, d ? 0 : 4));
      check("random latency", lat, ref_lat(ra, rb, d ? 0 : 4));
    end

    // Reset during SCAN aborts silently.
    @(negedge clk);
    a_v[0] = 16'h8000;
    b_v[0] = 16'h0000;
    in_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    in_valid_v[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    check("reset abort", status(0), 5'b10000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("no stale result", status(0), 5'b10000);
    end
    do_txn(0, 16'h8000, 16'h0000, 0, got, lat);
    check("post reset result", got, R_GT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
